// File: rtl/spi_boot_pkg.sv
// spi_boot_pkg: flash command opcodes and loader state encoding shared by the boot loader files
package spi_boot_pkg;
    localparam logic [7:0] CMD_RESET_CR   = 8'hFF;
    localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;
    localparam logic [7:0] CMD_READ       = 8'h03;
    typedef enum logic [3:0] {
        RESET_WAIT, CMD_FF, GAP1, CMD_AB, WAIT_RES, CMD_RD, RD_BYTE, WR_MEM, CLOSE, FINISH
    } state_t;
endpackage

// File: rtl/spi_boot_loader_if.sv
// spi_boot_loader_if: SPI flash pins plus RAM write handshake
// master: drives csb/sck/mosi and mem_addr/mem_wdata/mem_we; samples spi_miso and mem_ack
// slave: the flash/RAM side of the same signals
interface spi_boot_loader_if;
    logic        spi_csb;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    modport master(output spi_csb, spi_sck, spi_mosi, mem_addr, mem_wdata, mem_we, input spi_miso, mem_ack);
    modport slave(input spi_csb, spi_sck, spi_mosi, mem_addr, mem_wdata, mem_we, output spi_miso, mem_ack);
endinterface

// File: rtl/spi_byte_xfer.sv
// spi_byte_xfer: one SPI mode-0 byte, MSB first, 16*CLK_DIV clk_i cycles per byte
// ports: clk_i/rst; start+tx_byte launch a byte; busy while shifting; done_pulse marks the
// final cycle (rx_byte complete); sck/mosi/miso are the SPI pins
module spi_byte_xfer #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       busy,
    output logic       done_pulse,
    output logic       sck,
    output logic       mosi,
    output logic [7:0] rx_byte
);
    logic [15:0] div;
    logic [3:0]  half;
    logic [7:0]  sh;
    logic        tick;
    assign tick       = busy && div == 16'(CLK_DIV - 1);
    // done_pulse is combinational so a start in the same cycle chains the next byte with no SCK gap
    assign done_pulse = tick && half == 4'd15;
    assign mosi       = busy & sh[7];
    always_ff @(posedge clk_i) begin
        if (rst) begin
            busy    <= 1'b0;
            div     <= '0;
            half    <= '0;
            sh      <= '0;
            sck     <= 1'b0;
            rx_byte <= '0;
        end else if (start && (!busy || done_pulse)) begin
            busy <= 1'b1;
            div  <= '0;
            half <= '0;
            sh   <= tx_byte;
            sck  <= 1'b0;
        end else if (done_pulse) begin
            busy <= 1'b0;
            div  <= '0;
            half <= '0;
            sck  <= 1'b0;
        end else if (tick) begin
            div  <= '0;
            half <= half + 4'd1;
            sck  <= ~sck;
            if (!half[0]) rx_byte <= {rx_byte[6:0], miso};
            else sh <= {sh[6:0], 1'b0};
        end else if (busy) begin
            div <= div + 16'd1;
        end
    end
endmodule

// File: rtl/spi_boot_loader.sv
// spi_boot_loader: wakes the SPI boot flash, reads it from address 0 and copies
// RAM_START..RAM_END into RAM, then releases the CPU
// ports: clk_i/rst; boot_en (0 skips the copy); bus = SPI pins + RAM write handshake;
// cpu_hold (CPU in reset while high); done (sticky copy-complete flag)
module spi_boot_loader
    import spi_boot_pkg::*;
#(
    parameter logic [15:0] RAM_START = 16'h0000,
    parameter logic [15:0] RAM_END   = 16'h0FFF,
    parameter int          CLK_DIV   = 2,
    parameter int          CS_GAP    = 4,
    parameter int          RES_WAIT  = 64
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic                boot_en,
    spi_boot_loader_if.master   bus,
    output logic                cpu_hold,
    output logic                done
);
    state_t      state, state_n;
    logic [1:0]  step, step_n, bcnt, bcnt_n;
    logic [15:0] cnt, cnt_n;
    logic [16:0] addr, addr_n;
    logic [7:0]  wdata, wdata_n, tx_byte, rx_byte;
    logic        we, we_n, csb, csb_n, done_n;
    logic        start, busy, done_pulse;

    spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk_i(clk_i), .rst(rst), .start(start), .tx_byte(tx_byte), .miso(bus.spi_miso),
        .busy(busy), .done_pulse(done_pulse), .sck(bus.spi_sck), .mosi(bus.spi_mosi), .rx_byte(rx_byte)
    );

    assign bus.spi_csb   = csb;
    assign bus.mem_addr  = addr[15:0];
    assign bus.mem_wdata = wdata;
    assign bus.mem_we    = we;
    assign cpu_hold      = ~done;
    // only the opening byte of each command carries an opcode; address and read bytes are zero
    assign tx_byte = state == CMD_FF ? CMD_RESET_CR :
                     state == CMD_AB ? CMD_RELEASE_PD :
                     (state == CMD_RD && step == 2'd0) ? CMD_READ : 8'h00;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state <= RESET_WAIT;
            step  <= '0;
            bcnt  <= '0;
            cnt   <= '0;
            addr  <= {1'b0, RAM_START};
            wdata <= '0;
            we    <= 1'b0;
            csb   <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            step  <= step_n;
            bcnt  <= bcnt_n;
            cnt   <= cnt_n;
            addr  <= addr_n;
            wdata <= wdata_n;
            we    <= we_n;
            csb   <= csb_n;
            done  <= done_n;
        end
    end

    // step: 0 = launch byte, 1 = shifting, 2 = one idle cycle so SCK is already low when csb rises
    always_comb begin
        state_n = state;
        step_n  = step;
        bcnt_n  = bcnt;
        cnt_n   = cnt;
        addr_n  = addr;
        wdata_n = wdata;
        we_n    = we;
        start   = 1'b0;
        case (state)
            RESET_WAIT: begin
                state_n = boot_en ? CMD_FF : FINISH;
                step_n  = 2'd0;
            end
            CMD_FF, CMD_AB: begin
                if (step == 2'd0) begin
                    start  = !busy;
                    step_n = busy ? 2'd0 : 2'd1;
                end else if (step == 2'd1) begin
                    step_n = done_pulse ? 2'd2 : 2'd1;
                end else begin
                    state_n = state == CMD_FF ? GAP1 : WAIT_RES;
                    step_n  = 2'd0;
                    cnt_n   = '0;
                end
            end
            GAP1: begin
                if (cnt == 16'(CS_GAP - 1)) state_n = CMD_AB;
                else cnt_n = cnt + 16'd1;
            end
            WAIT_RES: begin
                if (cnt == 16'(RES_WAIT - 1)) state_n = CMD_RD;
                else cnt_n = cnt + 16'd1;
            end
            CMD_RD: begin
                if (step == 2'd0) begin
                    start  = !busy;
                    step_n = busy ? 2'd0 : 2'd1;
                    bcnt_n = '0;
                end else if (done_pulse) begin
                    // chain the next address byte, and after the last one the first data byte
                    start  = 1'b1;
                    bcnt_n = bcnt + 2'd1;
                    if (bcnt == 2'd3) state_n = RD_BYTE;
                end
            end
            RD_BYTE: begin
                if (step == 2'd0) begin
                    start  = !busy;
                    step_n = busy ? 2'd0 : 2'd1;
                end else if (done_pulse) begin
                    wdata_n = rx_byte;
                    we_n    = 1'b1;
                    state_n = WR_MEM;
                end
            end
            WR_MEM: begin
                if (we && bus.mem_ack) begin
                    we_n   = 1'b0;
                    step_n = 2'd0;
                    // 17-bit compare lets a full 64 KiB image finish without wrapping
                    if (addr == {1'b0, RAM_END}) state_n = CLOSE;
                    else begin
                        addr_n  = addr + 17'd1;
                        state_n = RD_BYTE;
                    end
                end
            end
            CLOSE:   state_n = FINISH;
            FINISH:  state_n = FINISH;
            default: state_n = RESET_WAIT;
        endcase
        csb_n  = !(state_n inside {CMD_FF, CMD_AB, CMD_RD, RD_BYTE, WR_MEM});
        done_n = done | (state == FINISH);
    end
endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader: directed checks of the SPI boot loader against a flash and RAM model
module tb_spi_boot_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1, ben0 = 1'b1, ben1 = 1'b1, ack0 = 1'b0, ack1 = 1'b0;
    logic hold0, done0, hold1, done1;
    int   bc0 = 0, bc1 = 0, checks = 0, errors = 0, mbase = 0;
    logic [7:0] sh0 = 8'h00;
    logic [7:0] mlog[$];
    logic [7:0] fl [16] = '{8'hC0, 8'h1B, 8'h05, 8'h7E, 8'hA5, 8'h3C, 8'h99, 8'h01,
                            8'hFE, 8'h42, 8'h80, 8'h2D, 8'h55, 8'hE7, 8'h10, 8'h6B};
    logic [7:0] cmd_exp [6] = '{8'hFF, 8'hAB, 8'h03, 8'h00, 8'h00, 8'h00};

    spi_boot_loader_if b0();
    spi_boot_loader_if b1();

    spi_boot_loader #(.RAM_START(16'h0000), .RAM_END(16'h000F), .CLK_DIV(1), .CS_GAP(4), .RES_WAIT(64)) dut0 (
        .clk_i(clk), .rst(rst0), .boot_en(ben0), .bus(b0), .cpu_hold(hold0), .done(done0));
    spi_boot_loader #(.RAM_START(16'hFFFE), .RAM_END(16'hFFFF), .CLK_DIV(2), .CS_GAP(4), .RES_WAIT(64)) dut1 (
        .clk_i(clk), .rst(rst1), .boot_en(ben1), .bus(b1), .cpu_hold(hold1), .done(done1));

    // flash: 4 command bytes, then image byte k = fl[k % 16], MSB first
    function automatic logic fbit(input int bc);
        logic [7:0] b;
        if (bc < 32) return 1'b0;
        b = fl[((bc - 32) / 8) % 16];
        return b[7 - (bc % 8)];
    endfunction

    assign b0.spi_miso = fbit(bc0);
    assign b1.spi_miso = fbit(bc1);
    assign b0.mem_ack  = ack0;
    assign b1.mem_ack  = ack1;

    always @(posedge b0.spi_sck or negedge b0.spi_csb)
        if (!b0.spi_sck) bc0 = 0;
        else begin
            sh0 = {sh0[6:0], b0.spi_mosi};
            if (bc0 % 8 == 7) mlog.push_back(sh0);
            bc0++;
        end

    always @(posedge b1.spi_sck or negedge b1.spi_csb)
        bc1 = !b1.spi_sck ? 0 : bc1 + 1;

    int nwr0 = 0, wt0 = 0, nfall0 = 0, hcnt0 = 0, edge_bad = 0, wesck_bad = 0;
    logic pcsb0 = 1'b1, psck0 = 1'b0;
    logic [15:0] waddr0[$];
    logic [7:0]  wdat0[$];
    int gaps0[$];
    always @(posedge clk) begin
        #1;
        if (!rst0 && b0.spi_csb != pcsb0 && (b0.spi_sck || psck0)) edge_bad++;
        if (b0.mem_we && b0.spi_sck) wesck_bad++;
        if (rst0) begin
            nwr0 = 0; wt0 = 0; ack0 = 1'b0; nfall0 = 0; hcnt0 = 0;
            waddr0.delete(); wdat0.delete(); gaps0.delete();
        end else begin
            if (!b0.spi_csb && pcsb0) begin
                nfall0++;
                if (hcnt0 > 0) gaps0.push_back(hcnt0);
                hcnt0 = 0;
            end else if (b0.spi_csb && (!pcsb0 || hcnt0 > 0)) hcnt0++;
            // third write is acked after 10 cycles, the rest after one
            if (ack0) ack0 = 1'b0;
            else if (b0.mem_we) begin
                wt0++;
                if (wt0 >= (nwr0 == 2 ? 10 : 1)) begin
                    ack0 = 1'b1;
                    waddr0.push_back(b0.mem_addr);
                    wdat0.push_back(b0.mem_wdata);
                    nwr0++;
                    wt0 = 0;
                end
            end
        end
        pcsb0 = b0.spi_csb;
        psck0 = b0.spi_sck;
    end

    int nwr1 = 0;
    logic [15:0] waddr1[$];
    logic [7:0]  wdat1[$];
    always @(posedge clk) begin
        #1;
        if (rst1) begin
            nwr1 = 0; ack1 = 1'b0; waddr1.delete(); wdat1.delete();
        end else if (ack1) ack1 = 1'b0;
        else if (b1.mem_we) begin
            ack1 = 1'b1;
            waddr1.push_back(b1.mem_addr);
            wdat1.push_back(b1.mem_wdata);
            nwr1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = d == 0 ? done0 : done1;
        end
        check(d == 0 ? "done0_in_budget" : "done1_in_budget", 32'(seen), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_csb", 32'(b0.spi_csb), 32'd1);
        check("rst_sck", 32'(b0.spi_sck), 32'd0);
        check("rst_mosi", 32'(b0.spi_mosi), 32'd0);
        check("rst_we", 32'(b0.mem_we), 32'd0);
        check("rst_addr", 32'(b0.mem_addr), 32'h0000);
        check("rst_wdata", 32'(b0.mem_wdata), 32'h00);
        check("rst_hold", 32'(hold0), 32'd1);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_addr1", 32'(b1.mem_addr), 32'hFFFE);

        // full boot, CLK_DIV=1, 16-byte image
        @(negedge clk);
        mbase = mlog.size();
        rst0 = 1'b0;
        wait_done(0, 5000);
        check("mosi_count", 32'(mlog.size() - mbase), 32'd22);
        for (int i = 0; i < 6; i++) check($sformatf("mosi_cmd%0d", i), 32'(mlog[mbase + i]), 32'(cmd_exp[i]));
        check("csb_sessions", 32'(nfall0), 32'd3);
        check("gap_count", 32'(gaps0.size()), 32'd2);
        check("gap_after_ff", 32'(gaps0[0] >= 4), 32'd1);
        check("gap_after_ab", 32'(gaps0[1] >= 64), 32'd1);
        check("writes", 32'(nwr0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("waddr%0d", i), 32'(waddr0[i]), 32'(i));
            check($sformatf("wdata%0d", i), 32'(wdat0[i]), 32'(fl[i]));
        end
        check("end_csb", 32'(b0.spi_csb), 32'd1);
        check("end_hold", 32'(hold0), 32'd0);
        check("end_done", 32'(done0), 32'd1);
        check("sck_at_csb_edge", 32'(edge_bad), 32'd0);
        check("sck_during_we", 32'(wesck_bad), 32'd0);

        // boot_en=0: straight to FINISH, no flash traffic
        @(negedge clk);
        rst0 = 1'b1;
        ben0 = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("skip_done", 32'(done0), 32'd1);
        check("skip_hold", 32'(hold0), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("skip_no_csb", 32'(nfall0), 32'd0);
        check("skip_csb_high", 32'(b0.spi_csb), 32'd1);

        // reset in the middle of data byte 2, then a clean restart
        @(negedge clk);
        rst0 = 1'b1;
        ben0 = 1'b1;
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        for (int i = 0; i < 3000 && !(nfall0 == 3 && bc0 >= 51); i++) @(negedge clk);
        check("mid_reached", 32'(nfall0 == 3 && bc0 >= 51), 32'd1);
        rst0 = 1'b1;
        mbase = mlog.size();
        @(posedge clk);
        #1;
        check("abort_csb", 32'(b0.spi_csb), 32'd1);
        check("abort_sck", 32'(b0.spi_sck), 32'd0);
        check("abort_we", 32'(b0.mem_we), 32'd0);
        check("abort_addr", 32'(b0.mem_addr), 32'h0000);
        check("abort_done", 32'(done0), 32'd0);
        check("abort_hold", 32'(hold0), 32'd1);
        @(negedge clk);
        rst0 = 1'b0;
        wait_done(0, 5000);
        check("restart_first", 32'(mlog[mbase]), 32'hFF);
        check("restart_second", 32'(mlog[mbase + 1]), 32'hAB);
        check("restart_writes", 32'(nwr0), 32'd16);
        check("restart_addr0", 32'(waddr0[0]), 32'h0000);
        check("restart_data0", 32'(wdat0[0]), 32'hC0);
        check("restart_addr15", 32'(waddr0[15]), 32'h000F);
        check("restart_data15", 32'(wdat0[15]), 32'(fl[15]));
        check("restart_sck_edge", 32'(edge_bad), 32'd0);

        // top-of-memory image: exactly FFFE and FFFF, no wrap to 0000
        @(negedge clk);
        rst1 = 1'b0;
        wait_done(1, 5000);
        repeat (5) @(posedge clk);
        #1;
        check("top_writes", 32'(nwr1), 32'd2);
        check("top_addr0", 32'(waddr1[0]), 32'hFFFE);
        check("top_addr1", 32'(waddr1[1]), 32'hFFFF);
        check("top_data0", 32'(wdat1[0]), 32'hC0);
        check("top_data1", 32'(wdat1[1]), 32'h1B);
        check("top_hold", 32'(hold1), 32'd0);
        check("top_csb", 32'(b1.spi_csb), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_boot_loader.md
Name: spi_boot_loader

Overview:
- Hardware boot loader that copies a SPI flash image into RAM, replacing the software copy loop.
- Acts as SPI mode-0 initiator toward the boot flash and as a write initiator on the RAM port.
- Sequence: wake the flash, issue READ (0x03) at address 0, stream bytes to RAM_START..RAM_END, then release the CPU.

Parameters:
- RAM_START, 16'h0000, first RAM address written (flash byte 0 lands here).
- RAM_END, 16'h0FFF, last RAM address written, inclusive; must satisfy RAM_END >= RAM_START.
- CLK_DIV, 2, SCK half-period in clk_i cycles; minimum 1.
- CS_GAP, 4, minimum clk_i cycles spi_csb stays high between commands.
- RES_WAIT, 64, clk_i cycles waited after the 0xAB command (flash tRES1).

Ports:
- clk_i  input  1  system clock
- rst  input  1  synchronous, active-high reset
- boot_en  input  1  sampled when leaving reset state; 0 = skip copy
- spi_csb  output  1  flash chip select, active low
- spi_sck  output  1  SPI clock, idles low
- spi_mosi  output  1  data to flash
- spi_miso  input  1  data from flash
- mem_addr  output  16  RAM write address
- mem_wdata  output  8  RAM write data
- mem_we  output  1  write request; held until mem_ack
- mem_ack  input  1  write accepted this cycle
- cpu_hold  output  1  holds CPU in reset while high
- done  output  1  copy finished; sticky until rst

Behaviour:
- Clock and reset:
  - One clock, clk_i. rst is synchronous and active-high.
  - During and after reset: spi_csb=1, spi_sck=0, spi_mosi=0, mem_we=0, mem_addr=RAM_START, mem_wdata=0, cpu_hold=1, done=0.
- SPI mode 0:
  - spi_mosi changes while spi_sck is low; it is valid at least CLK_DIV cycles before the rising edge.
  - spi_miso is sampled on the clk_i edge that drives spi_sck high.
  - Bytes are shifted MSB first. Each byte takes 16*CLK_DIV cycles.
  - spi_sck is low whenever spi_csb changes.
- State machine:
  - RESET_WAIT: first cycle after rst. If boot_en=0, go to FINISH. Otherwise go to CMD_FF.
  - CMD_FF: csb low, send 0xFF (exits continuous-read mode), csb high, go to GAP1.
  - GAP1: wait CS_GAP cycles, go to CMD_AB.
  - CMD_AB: csb low, send 0xAB, csb high, go to WAIT_RES.
  - WAIT_RES: wait RES_WAIT cycles, go to CMD_RD.
  - CMD_RD: csb low, send 0x03, 0x00, 0x00, 0x00 back to back (no SCK gap), go to RD_BYTE.
  - RD_BYTE: shift in one byte (MOSI=0), go to WR_MEM.
  - WR_MEM:
    - Assert mem_we with mem_addr=current address and mem_wdata=received byte. Hold until mem_ack.
    - SCK stays low and csb stays low while waiting; no timeout.
    - On ack: if address == RAM_END, go to CLOSE. Otherwise increment the address and go to RD_BYTE.
  - CLOSE: csb high, go to FINISH.
  - FINISH: cpu_hold=0, done=1 one cycle after entry. Terminal state.
- Image length is RAM_END-RAM_START+1 bytes. Use a 17-bit compare so RAM_START=0, RAM_END=16'hFFFF copies 65536 bytes with no early wrap.
- mem_ack seen while mem_we=0 is ignored.
- Exactly one RAM write per received byte; mem_we deasserts the cycle after mem_ack.
- rst mid-transfer aborts immediately to reset values, including csb=1 in the same cycle. The full sequence restarts from CMD_FF.

Decomposition:
- Shared package (spi_boot_pkg):
  - Command constants CMD_RESET_CR=8'hFF, CMD_RELEASE_PD=8'hAB, CMD_READ=8'h03.
  - State enum.
- Sub-module spi_byte_xfer:
  - Handles clock division, 8-bit shift, and the start/busy/done_pulse handshake.
  - Inputs tx_byte and miso; outputs rx_byte and sck.
  - Parameter CLK_DIV.
- The top FSM owns csb, gap/wait counters, the address counter and the memory handshake.

Test Plan:
- Reset with boot_en=1, CLK_DIV=1 -> MOSI bytes 0xFF | 0xAB | 0x03 0x00 0x00 0x00, with csb high >= 4 cycles between commands and >= 64 cycles after 0xAB. SCK is low at every csb edge.
- Flash model returns bytes 0xC0,0x1B,0x05...; RAM_END=16'h000F, mem_ack one cycle after mem_we -> 16 writes, addr 0x0000..0x000F with matching data. Then csb=1, done=1, cpu_hold=0.
- mem_ack delayed 10 cycles on the third byte -> SCK frozen low during the wait, no data loss, no duplicate write.
- boot_en=0 at reset -> no csb activity, done=1 and cpu_hold=0 within 2 cycles.
- rst asserted mid-byte of the data phase -> csb=1 and sck=0 on the next clk_i edge. After release, the sequence restarts from 0xFF and the address restarts at RAM_START.
- RAM_START=16'hFFFE, RAM_END=16'hFFFF -> exactly 2 writes (0xFFFE, 0xFFFF), no write to 0x0000, done=1.
